// File: rtl/product_accum_pkg.sv
// Shared types and default constants for the product accumulator.
package product_accum_pkg;

    // Default accumulator width and number of products summed per result.
    localparam int ACC_W_DEFAULT = 10;
    localparam int BATCH_DEFAULT = 8;

    // Width of the per-batch product counter; holds BATCH values up to 15.
    localparam int COUNT_W = 4;

    // Batch control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : product_accum_pkg

// File: rtl/product_accumulator_if.sv
// Handshake and result bus between a product source and the accumulator.
interface product_accumulator_if
    import product_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
);
    logic [7:0]         product;
    logic               in_valid;
    logic               in_ready;
    logic               clear;
    logic [ACC_W-1:0]   acc_out;
    logic               out_valid;
    logic               out_ready;
    logic [COUNT_W-1:0] count_out;
    logic               overflow;

    // Upstream/downstream side: supplies products and consumes results.
    modport master (
        output product, in_valid, clear, out_ready,
        input  in_ready, acc_out, out_valid, count_out, overflow
    );

    // Accumulator side.
    modport slave (
        input  product, in_valid, clear, out_ready,
        output in_ready, acc_out, out_valid, count_out, overflow
    );
endinterface : product_accumulator_if

// File: rtl/sat_adder.sv
// Adds a zero-extended 8-bit product to the running sum.
// Macro PRODUCT_ACCUM_SATURATE_EN: clamp at all-ones on carry-out and flag
// it; otherwise the sum wraps and the flag is tied low.
module sat_adder #(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [7:0]       product_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             overflow_o
);

`ifdef PRODUCT_ACCUM_SATURATE_EN
    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, acc_i} + (ACC_W + 1)'(product_i);

    // Clamp the sum to its maximum whenever the addition carries out.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        sum_o      = full_sum[ACC_W-1:0];
        overflow_o = full_sum[ACC_W];
        if (full_sum[ACC_W]) begin
            sum_o = '1;
        end
    end
`else
    // Modulo-2^ACC_W sum; the carry is simply dropped.
    assign sum_o      = acc_i + ACC_W'(product_i);
    assign overflow_o = 1'b0;
`endif

endmodule : sat_adder

// File: rtl/product_accumulator.sv
// Sums BATCH products from an upstream 4x4 multiplier and presents the
// result with a valid/ready handshake. Saturation is selected with the
// macro PRODUCT_ACCUM_SATURATE_EN (see sat_adder); default build wraps.
module product_accumulator
    import product_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int BATCH = BATCH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    product_accumulator_if.slave bus
);

    localparam logic [COUNT_W-1:0] BATCH_CNT = COUNT_W'(BATCH);

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               overflow_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               add_ovf;
    logic               accept;
    logic               go_idle;

    // A product is taken only when both sides agree on the same cycle.
    assign accept  = bus.in_valid & in_ready_q;
    assign count_d = count_q + COUNT_W'(1);

    // Clear wins over everything; otherwise a delivered result ends the batch.
    assign go_idle = bus.clear | (out_valid_q & bus.out_ready);

    // In IDLE acc_q is zero, so the first accepted product loads directly.
    sat_adder #(
        .ACC_W (ACC_W)
    ) u_sat_adder (
        .acc_i      (acc_q),
        .product_i  (bus.product),
        .sum_o      (acc_d),
        .overflow_o (add_ovf)
    );

    // Batch FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n || go_idle) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q      <= acc_d;
                        overflow_q <= overflow_q | add_ovf;
                        count_q    <= count_d;
                        if (count_d == BATCH_CNT) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    // Result held until downstream accepts it (handled by go_idle).
                    state_q <= DONE;
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_q;
    assign bus.count_out = count_q;
    assign bus.overflow  = overflow_q;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator (default ACC_W=10, BATCH=8).
module tb_product_accumulator;
    import product_accum_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    product_accumulator_if #(.ACC_W(10)) bus ();

    product_accumulator #(
        .ACC_W (10),
        .BATCH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            bus.product  = p;
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_acc"},       32'(bus.acc_out),   0);
        check({tag, "_count"},     32'(bus.count_out), 0);
        check({tag, "_ovf"},       32'(bus.overflow),  0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  1);
    endtask

    int exp_sat_acc;
    int exp_sat_ovf;

    initial begin
`ifdef PRODUCT_ACCUM_SATURATE_EN
        exp_sat_acc = 1023;
        exp_sat_ovf = 1;
`else
        exp_sat_acc = 776;
        exp_sat_ovf = 0;
`endif
        rst_n         = 1'b0;
        bus.product   = 8'd0;
        bus.in_valid  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst_n = 1'b1;

        // Eight products of 10 back-to-back.
        feed(8'd10, 7);
        check("b2b_count7",      32'(bus.count_out), 7);
        check("b2b_valid_early", 32'(bus.out_valid), 0);
        check("b2b_acc70",       32'(bus.acc_out),   70);
        feed(8'd10, 1);
        check("b2b_out_valid", 32'(bus.out_valid), 1);
        check("b2b_acc",       32'(bus.acc_out),   80);
        check("b2b_count",     32'(bus.count_out), 8);
        check("b2b_ovf",       32'(bus.overflow),  0);
        check("b2b_in_ready",  32'(bus.in_ready),  0);
        release_result();
        check_idle("b2b_release");

        // Eight products of 225: saturate or wrap depending on build.
        feed(8'd225, 8);
        check("big_out_valid", 32'(bus.out_valid), 1);
        check("big_acc",       32'(bus.acc_out),   32'(exp_sat_acc));
        check("big_ovf",       32'(bus.overflow),  32'(exp_sat_ovf));
        release_result();
        check_idle("big_release");

        // Result held for 5 cycles with in_valid pulses that must be ignored.
        feed(8'd7, 8);
        bus.product = 8'd99;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            tick();
            check("hold_acc",       32'(bus.acc_out),   56);
            check("hold_count",     32'(bus.count_out), 8);
            check("hold_in_ready",  32'(bus.in_ready),  0);
            check("hold_out_valid", 32'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
        release_result();
        check_idle("hold_release");

        // Clear after 4, 9, 6 with a same-cycle product that must be dropped.
        feed(8'd4, 1);
        feed(8'd9, 1);
        feed(8'd6, 1);
        check("clr_pre_acc",   32'(bus.acc_out),   19);
        check("clr_pre_count", 32'(bus.count_out), 3);
        bus.clear    = 1'b1;
        bus.product  = 8'd5;
        bus.in_valid = 1'b1;
        tick();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check_idle("clr");
        feed(8'd2, 1);
        check("clr_restart_acc",   32'(bus.acc_out),   2);
        check("clr_restart_count", 32'(bus.count_out), 1);

        // Clear in DONE while out_ready is low also returns to IDLE.
        feed(8'd1, 7);
        check("clr_done_valid", 32'(bus.out_valid), 1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_idle("clr_done");

        // Reset mid-batch after five products.
        feed(8'd1, 5);
        check("rst_pre_count", 32'(bus.count_out), 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("rst_mid");
        feed(8'd1, 8);
        check("rst_after_acc",   32'(bus.acc_out),   8);
        check("rst_after_valid", 32'(bus.out_valid), 1);
        release_result();

        // in_valid toggling every other cycle with product 3.
        bus.product = 8'd3;
        for (int i = 0; i < 15; i++) begin
            bus.in_valid = (i % 2 == 0);
            tick();
            if (i == 1) begin
                check("tog_count_hold", 32'(bus.count_out), 1);
            end
            if (i == 13) begin
                check("tog_valid_early", 32'(bus.out_valid), 0);
                check("tog_count7",      32'(bus.count_out), 7);
            end
        end
        bus.in_valid = 1'b0;
        check("tog_out_valid", 32'(bus.out_valid), 1);
        check("tog_acc",       32'(bus.acc_out),   24);
        check("tog_count",     32'(bus.count_out), 8);
        release_result();
        check_idle("tog_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_product_accumulator
